// File: rtl/pulse_indicator_if.sv
// Event/status bundle between control logic and the LED flasher.
interface pulse_indicator_if #(
    parameter int PEND_W = 4
);
    logic              pulse;
    logic              clear;
    logic              led;
    logic              busy;
    logic [PEND_W-1:0] pending;
    logic              overflow;

    modport master (output pulse, clear, input led, busy, pending, overflow);
    modport slave  (input pulse, clear, output led, busy, pending, overflow);
endinterface

// File: rtl/pulse_indicator.sv
// Turns single-cycle event pulses into fixed-length LED flashes, one flash
// per event, with a saturating queue of events that arrive mid-flash.
module pulse_indicator #(
    parameter int TICK_MAX  = 1000000,
    parameter int ON_TICKS  = 50,
    parameter int OFF_TICKS = 50,
    parameter int PEND_W    = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    pulse_indicator_if.slave   bus
);
    localparam int PH_MAX = (ON_TICKS > OFF_TICKS) ? ON_TICKS : OFF_TICKS;
    localparam int PH_W   = $clog2(PH_MAX + 1);
    localparam int PS_W   = $clog2(TICK_MAX);
    localparam logic [PS_W-1:0]   PS_LAST  = PS_W'(TICK_MAX - 1);
    localparam logic [PEND_W-1:0] PEND_MAX = '1;

    typedef enum logic [1:0] {IDLE = 2'd0, ON = 2'd1, OFF = 2'd2} state_t;

    state_t            state, nxt;
    logic [PS_W-1:0]   ps;
    logic [PH_W-1:0]   phase;
    logic [PEND_W-1:0] pend;
    logic              ovf;
    logic              tick, phase_end, start;
    logic              enter_on, enter_off;
    logic              inc, dec, ovf_set;

    // Next-state and per-cycle event decode.
    always_comb begin
        nxt       = state;
        tick      = (ps == PS_LAST);
        phase_end = tick && (phase == PH_W'(1));
        start     = bus.pulse || (pend != '0);
        case (state)
            IDLE:    if (start) nxt = ON;
            ON:      if (phase_end) nxt = OFF;
            OFF:     if (phase_end) nxt = start ? ON : IDLE;
            default: nxt = IDLE;
        endcase
        enter_on  = (nxt == ON)  && (state != ON);
        enter_off = (nxt == OFF) && (state != OFF);
        inc       = bus.pulse;
        // A pulse that itself starts a flash is consumed immediately.
        dec       = enter_on && ((pend != '0) || bus.pulse);
        ovf_set   = inc && !dec && (pend == PEND_MAX);
    end

    // State register; led/busy registered from the next state so the
    // outputs line up with the state and reset drops them at once.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            bus.led  <= 1'b0;
            bus.busy <= 1'b0;
        end else begin
            state    <= nxt;
            bus.led  <= (nxt == ON);
            bus.busy <= (nxt != IDLE);
        end
    end

    // Prescaler and phase counter, restarted on every phase entry so each
    // phase is exactly N ticks long.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ps    <= '0;
            phase <= '0;
        end else begin
            if (enter_on || enter_off || state == IDLE || tick)
                ps <= '0;
            else
                ps <= ps + PS_W'(1);

            if (enter_on)
                phase <= PH_W'(ON_TICKS);
            else if (enter_off)
                phase <= PH_W'(OFF_TICKS);
            else if (tick && state != IDLE)
                phase <= phase - PH_W'(1);
        end
    end

    // Saturating pending queue and sticky overflow (set beats clear).
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pend <= '0;
            ovf  <= 1'b0;
        end else begin
            case ({inc, dec})
                2'b10:   if (pend != PEND_MAX) pend <= pend + PEND_W'(1);
                2'b01:   pend <= pend - PEND_W'(1);
                default: pend <= pend;
            endcase
            if (ovf_set)
                ovf <= 1'b1;
            else if (bus.clear)
                ovf <= 1'b0;
        end
    end

    assign bus.pending  = pend;
    assign bus.overflow = ovf;
endmodule
